// File: rtl/fft_output_buffer.sv
// FFT output buffer: circular word store feeding a registered req/ans
// handshake, with frame-boundary pulse and sticky overflow flag.
module fft_output_buffer #(
   parameter int DATA_W    = 16,
   parameter int DEPTH     = 16,
   parameter int FRAME_LEN = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [DATA_W-1:0]        data_i,
   output logic                     full_o,
   output logic                     req_o,
   input  logic                     ans_i,
   output logic [DATA_W-1:0]        data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     frame_done_o,
   output logic                     ovf_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;

   typedef enum logic {EMPTY, HOLD} state_t;

   state_t              state_q, state_d;
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [AW:0]         count_q, count_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [FW-1:0]       fcnt_q, fcnt_d;
   logic                frame_done_q, frame_done_d;
   logic                ovf_q, ovf_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                xfer;
   logic                pop;
   logic                push;
   logic                full;

   // Storage array: written only when a word is accepted; no reset needed.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= data_i;
   end

   // Next-state: handshake, storage pop/push, FSM, frame counter, overflow.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      data_d       = data_q;
      fcnt_d       = fcnt_q;
      frame_done_d = 1'b0;
      ovf_d        = ovf_q;

      full = (count_q == (AW+1)'(DEPTH));
      xfer = (state_q == HOLD) && ans_i;
      // Refill the output register whenever it is empty or being drained.
      pop  = (count_q != '0) && ((state_q == EMPTY) || xfer);
      // A full store still accepts a write if a word leaves at the same edge.
      push = en && (!full || pop);

      unique case (state_q)
         EMPTY: if (pop) state_d = HOLD;
         HOLD:  if (xfer && !pop) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase

      if (pop) begin
         data_d   = mem_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

      if (en && !push) ovf_d = 1'b1;

      if (xfer) begin
         if (fcnt_q == FW'(FRAME_LEN-1)) begin
            fcnt_d       = '0;
            frame_done_d = 1'b1;
         end else begin
            fcnt_d = fcnt_q + FW'(1);
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= EMPTY;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         data_q       <= '0;
         fcnt_q       <= '0;
         frame_done_q <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         data_q       <= data_d;
         fcnt_q       <= fcnt_d;
         frame_done_q <= frame_done_d;
         ovf_q        <= ovf_d;
      end
   end

   // Output mapping.
   always_comb begin
      req_o        = (state_q == HOLD);
      data_o       = data_q;
      count_o      = count_q;
      full_o       = (count_q == (AW+1)'(DEPTH));
      frame_done_o = frame_done_q;
      ovf_o        = ovf_q;
   end

endmodule

// File: tb/tb_fft_output_buffer.sv
// Scoreboard bench for fft_output_buffer: stimulus feeds a queue-level
// model and pushes accepted words; a monitor checks data_o against them.
module tb_fft_output_buffer;

   localparam int DW    = 16;
   localparam int DEPTH = 16;
   localparam int FL    = 16;

   logic            clk;
   logic            rst;
   logic            en;
   logic [DW-1:0]   data_i;
   logic            full_o;
   logic            req_o;
   logic            ans_i;
   logic [DW-1:0]   data_o;
   logic [4:0]      count_o;
   logic            frame_done_o;
   logic            ovf_o;

   fft_output_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .FRAME_LEN(FL)) dut (
      .clk(clk), .rst(rst), .en(en), .data_i(data_i), .full_o(full_o),
      .req_o(req_o), .ans_i(ans_i), .data_o(data_o), .count_o(count_o),
      .frame_done_o(frame_done_o), .ovf_o(ovf_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   // Reference model: words waiting in storage, whether one is presented,
   // how many transfers into the current frame, and expected flags.
   logic [DW-1:0] store_q[$];
   logic [DW-1:0] exp_q[$];
   bit            hold;
   int            fc;
   bit            done_exp;
   bit            ovf_exp;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_clear();
      store_q.delete();
      exp_q.delete();
      hold = 0; fc = 0; done_exp = 0; ovf_exp = 0;
   endtask

   // One clock: check outputs against the model, drive inputs, advance model.
   task automatic cycle(input bit e, input logic [DW-1:0] d, input bit a);
      bit xfer, pp, acc;
      @(negedge clk);
      chk("count_o", int'(count_o), store_q.size());
      chk("full_o", int'(full_o), int'(store_q.size() == DEPTH));
      chk("req_o", int'(req_o), int'(hold));
      chk("ovf_o", int'(ovf_o), int'(ovf_exp));
      chk("frame_done_o", int'(frame_done_o), int'(done_exp));
      if (frame_done_o) pulses++;
      en = e; data_i = d; ans_i = a;
      xfer = hold && a;
      pp   = (store_q.size() > 0) && (!hold || xfer);
      acc  = e && (store_q.size() < DEPTH || pp);
      if (e && !acc) ovf_exp = 1;
      done_exp = xfer && (fc == FL-1);
      if (xfer) fc = (fc + 1) % FL;
      if (pp) begin
         void'(store_q.pop_front());
         hold = 1;
      end else if (xfer) begin
         hold = 0;
      end
      if (acc) begin
         store_q.push_back(d);
         exp_q.push_back(d);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " req_o"}, int'(req_o), 0);
      chk({tag, " data_o"}, int'(data_o), 0);
      chk({tag, " count_o"}, int'(count_o), 0);
      chk({tag, " full_o"}, int'(full_o), 0);
      chk({tag, " frame_done_o"}, int'(frame_done_o), 0);
      chk({tag, " ovf_o"}, int'(ovf_o), 0);
   endtask

   // Asynchronous reset mid-cycle; inputs toggled during reset must be ignored.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; en = 1'b0; ans_i = 1'b0;
      model_clear();
      #1 check_zero("reset");
      #1 en = 1'b1; ans_i = 1'b1; data_i = 16'hBEEF;
      @(negedge clk);
      en = 1'b0; ans_i = 1'b0; rst = 1'b1;
      pulses = 0;
   endtask

   // Monitor: whenever a word is presented it must be the oldest accepted one;
   // it is retired when the device accepts it.
   always begin
      @(negedge clk);
      #1;
      if (rst && req_o) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL data_o: presented %h with no word expected at %0t", data_o, $time);
         end else begin
            if (data_o !== exp_q[0]) begin
               errors++;
               $display("FAIL data_o: got %h expected %h at %0t", data_o, exp_q[0], $time);
            end
            if (ans_i) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      rst = 1'b0; en = 1'b0; ans_i = 1'b0; data_i = '0;
      model_clear();
      #1 check_zero("power-on");
      @(negedge clk);
      rst = 1'b1;

      // Single word held, then accepted; data_o keeps its value afterwards.
      cycle(1, 16'h1234, 0);
      cycle(0, 0, 0);
      cycle(0, 0, 1);
      cycle(0, 0, 0);
      chk("single data_o hold", int'(data_o), 'h1234);

      // Streaming two frames at full rate.
      do_reset();
      for (int i = 0; i < 32; i++) cycle(1, DW'(i), 1);
      for (int i = 0; i < 5; i++) cycle(0, 0, 1);
      chk("stream frame pulses", pulses, 2);
      chk("stream ovf_o", int'(ovf_o), 0);

      // Overflow: 18 writes with no acceptance, last one dropped.
      do_reset();
      for (int i = 0; i < 18; i++) cycle(1, DW'(i), 0);
      cycle(0, 0, 0);
      chk("ovf count_o", int'(count_o), 16);
      chk("ovf full_o", int'(full_o), 1);
      chk("ovf ovf_o", int'(ovf_o), 1);
      for (int i = 0; i < 20; i++) cycle(0, 0, 1);
      chk("ovf drained", exp_q.size(), 0);

      // Full store with simultaneous write and transfer.
      do_reset();
      for (int i = 0; i < 17; i++) cycle(1, DW'(i), 0);
      cycle(1, 16'd100, 1);
      cycle(0, 0, 0);
      chk("full wr+pop count_o", int'(count_o), 16);
      chk("full wr+pop ovf_o", int'(ovf_o), 0);
      for (int i = 0; i < 20; i++) cycle(0, 0, 1);

      // Reset mid-frame, then one full frame gives one pulse.
      do_reset();
      for (int i = 0; i < 9; i++) cycle(1, DW'(i), 0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 1);
      cycle(0, 0, 0);
      chk("midframe count_o", int'(count_o), 3);
      do_reset();
      for (int i = 0; i < 16; i++) cycle(1, DW'(i + 50), 1);
      for (int i = 0; i < 5; i++) cycle(0, 0, 1);
      chk("post-reset frame pulses", pulses, 1);

      // Random traffic in phases of varying acceptance rate.
      do_reset();
      for (int p = 0; p < 12; p++) begin
         int ans_pct;
         int en_pct;
         ans_pct = $urandom_range(10, 100);
         en_pct  = $urandom_range(20, 100);
         for (int i = 0; i < 200; i++)
            cycle($urandom_range(1, 100) <= en_pct, DW'($urandom),
                  $urandom_range(1, 100) <= ans_pct);
      end
      for (int i = 0; i < 40; i++) cycle(0, 0, 1);
      chk("random drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
